// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and iteration count for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  // MUL shares the signed path with MULH; its low half is sign-agnostic anyway.
  function automatic logic a_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// {hi,lo} is the double-width accumulator; opnd is the multiplicand or divisor magnitude.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          is_div,
  input  logic [DW-1:0] hi,
  input  logic [DW-1:0] lo,
  input  logic [DW-1:0] opnd,
  output logic [DW-1:0] hi_nxt,
  output logic [DW-1:0] lo_nxt
);

  logic [DW:0]   sum;
  logic [DW:0]   shifted;
  logic [DW-1:0] diff;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[DW-1]};
    ge      = shifted >= {1'b0, opnd};
    // When ge holds the difference is below opnd, so the low DW bits are exact.
    diff    = shifted[DW-1:0] - opnd;
    if (is_div) begin
      hi_nxt = ge ? diff : shifted[DW-1:0];
      lo_nxt = {lo[DW-2:0], ge};
    end else begin
      hi_nxt = sum[DW:1];
      lo_nxt = {sum[0], lo[DW-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-cycle run, done one cycle later; div-by-zero/overflow finish in cycle 1.
// No backpressure: start is only sampled in IDLE, busy stalls the issuing core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    funct3,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  op_e           op_q;
  logic [DW-1:0] acc_hi, acc_lo, opnd;
  logic          neg_q, neg_r;

  op_e           op_in;
  logic          sgn_a, sgn_b;
  logic [DW-1:0] mag_a, mag_b;
  logic          div_zero, div_ovf, short_op;
  logic [DW-1:0] short_res;

  always_comb begin
    op_in     = op_e'(funct3);
    sgn_a     = a_signed(op_in) & op_a[DW-1];
    sgn_b     = b_signed(op_in) & op_b[DW-1];
    mag_a     = sgn_a ? -op_a : op_a;
    mag_b     = sgn_b ? -op_b : op_b;
    div_zero  = is_div(op_in) && (op_b == '0);
    div_ovf   = (op_in == OP_DIV || op_in == OP_REM) && (op_a == MIN_NEG) && (op_b == '1);
    short_op  = div_zero | div_ovf;
    short_res = '0;
    case (op_in)
      OP_DIV, OP_DIVU: short_res = div_zero ? '1 : MIN_NEG;
      OP_REM, OP_REMU: short_res = div_zero ? op_a : '0;
      default:         short_res = '0;
    endcase
  end

  logic          op_is_div;
  logic [DW-1:0] step_hi, step_lo;

  assign op_is_div = is_div(op_q);

  muldiv_step #(.DW(DW)) u_step (
    .is_div (op_is_div),
    .hi     (acc_hi),
    .lo     (acc_lo),
    .opnd   (opnd),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // Sign fix-up is applied to the last step's output so result is ready in DONE.
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo, rem, final_res;

  always_comb begin
    prod      = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    quo       = neg_q ? -step_lo : step_lo;
    rem       = neg_r ? -step_hi : step_hi;
    final_res = '0;
    case (op_q)
      OP_MUL:                      final_res = prod[DW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*DW-1:DW];
      OP_DIV, OP_DIVU:             final_res = quo;
      default:                     final_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = short_op ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_q   <= OP_MUL;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (state == S_IDLE && start) begin
      op_q   <= op_in;
      cnt    <= '0;
      neg_q  <= sgn_a ^ sgn_b;
      neg_r  <= sgn_a;
      acc_hi <= '0;
      if (is_div(op_in)) begin
        acc_lo <= mag_a;
        opnd   <= mag_b;
      end else begin
        acc_lo <= mag_b;
        opnd   <= mag_a;
      end
      if (short_op) result <= short_res;
    end else if (state == S_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CW'(1);
      if (cnt == CNT_LAST) result <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_unit #(.DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit busy_ok;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) lat = c;
      else begin @(posedge clk); @(negedge clk); end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, result, exp);
    chk({tag, " busy while active"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk({tag, " done one cycle"}, {31'b0, done}, 32'd0);
    chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " result held"}, result, exp);
  endtask

  logic [31:0] hist [0:40];
  logic [31:0] ra, rb, hb, dres;
  logic [2:0]  rf;
  int          ndone, dcyc, b34, b35, sel;

  initial begin
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // reset in cycle 10 of a multiply aborts it without a done pulse
    funct3 = 3'd0; op_a = $urandom; op_b = $urandom; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort no done", ndone, 0);

    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    for (int i = 0; i < 24; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb));
    end

    // start held high while op_a changes every cycle
    hb = $urandom;
    funct3 = 3'd0; op_b = hb; op_a = $urandom; hist[0] = op_a; start = 1'b1;
    ndone = 0; dcyc = 0; dres = '0; b34 = 1; b35 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (dcyc == 0) begin dcyc = c; dres = result; end
      end
      if (c == 34) b34 = int'(busy);
      if (c == 35) b35 = int'(busy);
      op_a = $urandom; hist[c] = op_a;
      if (c == 40) start = 1'b0;
    end
    chk("held start done count", ndone, 1);
    chk("held start done cycle", dcyc, 33);
    chk("held start result", dres, model(3'd0, hist[0], hb));
    chk("held start idle c34", b34, 0);
    chk("held start accept c34", b35, 1);
    dcyc = 0; dres = '0;
    for (int c = 41; c <= 80 && dcyc == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) begin dcyc = c; dres = result; end
    end
    chk("second op done cycle", dcyc, 67);
    chk("second op result", dres, model(3'd0, hist[34], hb));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
